// File: rtl/audio_nios_sysid_checker.sv
// Avalon-MM read master that checks the sysid slave (ID @0, timestamp @1) against build-time values.
// Optional feature: define SYSID_CHECK_RETRY_EN to retry failed or timed-out checks up to MAX_RETRY times.
module audio_nios_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID  = 32'd0,
  parameter logic [31:0] EXPECTED_TS  = 32'd1387077895,
  parameter int unsigned READ_LATENCY = 0,
  parameter int unsigned TIMEOUT      = 255,
  parameter int unsigned MAX_RETRY    = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        timeout_err,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_ID  = 3'd1,
    LAT_ID = 3'd2,
    RD_TS  = 3'd3,
    LAT_TS = 3'd4,
    CHECK  = 3'd5
  } state_t;

  localparam logic [16:0] TIMEOUT_W = 17'(TIMEOUT);
  localparam logic [1:0]  LAT_CAP   = 2'(READ_LATENCY - 1);
  localparam logic [1:0]  LAT_END   = 2'(READ_LATENCY);

  state_t      state_q, state_d;
  logic [15:0] stall_q, stall_d;
  logic [1:0]  lat_q, lat_d;
  logic        pend_q;
  logic        pass_q, pass_d;
  logic        tmo_q, tmo_d;
  logic [31:0] id_q, id_d;
  logic [31:0] ts_q, ts_d;
  logic        attempt_end;
  logic        attempt_ok;
  logic        attempt_to;
  logic        start_go;

`ifdef SYSID_CHECK_RETRY_EN
  localparam logic [7:0] MAX_RETRY_W = 8'(MAX_RETRY);
  logic [7:0] retry_q, retry_d;
`else
  localparam int unsigned unused_max_retry = MAX_RETRY;
`endif

  always_comb begin
    state_d     = state_q;
    stall_d     = stall_q;
    lat_d       = lat_q;
    pass_d      = pass_q;
    tmo_d       = tmo_q;
    id_d        = id_q;
    ts_d        = ts_q;
    attempt_end = 1'b0;
    attempt_ok  = 1'b0;
    attempt_to  = 1'b0;
    start_go    = 1'b0;
`ifdef SYSID_CHECK_RETRY_EN
    retry_d     = retry_q;
`endif

    case (state_q)
      IDLE: start_go = start | pend_q;
      RD_ID, RD_TS: begin
        if (avm_waitrequest) begin
          if (({1'b0, stall_q} + 17'd1) >= TIMEOUT_W) begin
            attempt_end = 1'b1;
            attempt_to  = 1'b1;
          end else begin
            stall_d = stall_q + 16'd1;
          end
        end else begin
          lat_d   = 2'd0;
          state_d = (state_q == RD_ID) ? LAT_ID : LAT_TS;
          if (READ_LATENCY == 0) begin
            if (state_q == RD_ID) id_d = avm_readdata;
            else                  ts_d = avm_readdata;
          end
        end
      end
      // The final cycle of LAT_x is the bus turnaround that drops avm_read after accept.
      LAT_ID, LAT_TS: begin
        lat_d = lat_q + 2'd1;
        if ((READ_LATENCY != 0) && (lat_q == LAT_CAP)) begin
          if (state_q == LAT_ID) id_d = avm_readdata;
          else                   ts_d = avm_readdata;
        end
        if (lat_q == LAT_END) begin
          if (state_q == LAT_ID) begin
            state_d = RD_TS;
            stall_d = 16'd0;
          end else begin
            attempt_end = 1'b1;
            attempt_ok  = (id_q == EXPECTED_ID) && (ts_q == EXPECTED_TS);
          end
        end
      end
      CHECK: begin
        state_d  = IDLE;
        start_go = start;
      end
      default: state_d = IDLE;
    endcase

`ifdef SYSID_CHECK_RETRY_EN
    if (attempt_end) begin
      if (!attempt_ok && (retry_q < MAX_RETRY_W)) begin
        retry_d = retry_q + 8'd1;
        state_d = RD_ID;
        stall_d = 16'd0;
      end else begin
        state_d = CHECK;
        pass_d  = attempt_ok;
        tmo_d   = attempt_to;
      end
    end
`else
    if (attempt_end) begin
      state_d = CHECK;
      pass_d  = attempt_ok;
      tmo_d   = attempt_to;
    end
`endif

    if (start_go) begin
      state_d = RD_ID;
      stall_d = 16'd0;
      pass_d  = 1'b0;
      tmo_d   = 1'b0;
`ifdef SYSID_CHECK_RETRY_EN
      retry_d = 8'd0;
`endif
    end
  end

  // pend_q queues the automatic check that follows every reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      stall_q <= 16'd0;
      lat_q   <= 2'd0;
      pend_q  <= 1'b1;
      pass_q  <= 1'b0;
      tmo_q   <= 1'b0;
      id_q    <= 32'd0;
      ts_q    <= 32'd0;
`ifdef SYSID_CHECK_RETRY_EN
      retry_q <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
      lat_q   <= lat_d;
      pend_q  <= 1'b0;
      pass_q  <= pass_d;
      tmo_q   <= tmo_d;
      id_q    <= id_d;
      ts_q    <= ts_d;
`ifdef SYSID_CHECK_RETRY_EN
      retry_q <= retry_d;
`endif
    end
  end

  // Gated by reset so an in-flight read is withdrawn in the very cycle reset is sampled.
  assign avm_read    = ((state_q == RD_ID) || (state_q == RD_TS)) && !reset;
  assign avm_address = (state_q == RD_TS) && !reset;
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == CHECK);
  assign pass        = pass_q;
  assign timeout_err = tmo_q;
  assign id_value    = id_q;
  assign ts_value    = ts_q;

endmodule
